// File: rtl/piezo_tone_gen.sv
// Piezo buzzer tone generator: plays one note at a time, a square wave for
// NOTE_TICKS cycles followed by GAP_TICKS silent cycles.
module piezo_tone_gen #(
   parameter int NOTE_TICKS = 5000000,
   parameter int GAP_TICKS  = 500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] note_in,
   input  logic       note_valid,
   output logic       note_ready,
   input  logic       stop,
   output logic       piezo,
   output logic       busy,
   output logic       note_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TONE = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [23:0] NOTE_LAST = 24'(NOTE_TICKS - 1);
   localparam logic [23:0] GAP_LAST  = (GAP_TICKS > 0) ? 24'(GAP_TICKS - 1) : 24'd0;
   localparam logic        HAS_GAP   = (GAP_TICKS > 0);

   state_t      state, state_next;
   logic [3:0]  note_q, note_next;
   logic [16:0] half_cnt, half_next;
   logic [23:0] dur_cnt, dur_next;
   logic        piezo_next;
   logic        done_next;
   logic [16:0] half_period;
   logic        accept;

   // Half-period in clk cycles; zero marks a rest.
   always_comb begin
      case (note_q)
         4'd1:    half_period = 17'd95556;
         4'd2:    half_period = 17'd85131;
         4'd3:    half_period = 17'd75843;
         4'd4:    half_period = 17'd71586;
         4'd5:    half_period = 17'd63776;
         4'd6:    half_period = 17'd56818;
         4'd7:    half_period = 17'd50619;
         4'd8:    half_period = 17'd47778;
         default: half_period = 17'd0;
      endcase
   end

   // stop and reset both hold off a new note, so ready drops with them.
   assign note_ready = (state == IDLE) && reset && !stop;
   assign busy       = (state != IDLE);
   assign accept     = note_valid && note_ready;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      state_next = state;
      note_next  = note_q;
      half_next  = half_cnt;
      dur_next   = dur_cnt;
      piezo_next = piezo;
      done_next  = 1'b0;

      unique case (state)
         IDLE: begin
            piezo_next = 1'b0;
            half_next  = '0;
            dur_next   = '0;
            if (accept) begin
               state_next = TONE;
               note_next  = note_in;
            end
         end

         TONE: begin
            if (stop) begin
               state_next = IDLE;
               piezo_next = 1'b0;
               half_next  = '0;
               dur_next   = '0;
            end else if (dur_cnt == NOTE_LAST) begin
               piezo_next = 1'b0;
               half_next  = '0;
               dur_next   = '0;
               if (HAS_GAP) begin
                  state_next = GAP;
               end else begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end
            end else begin
               dur_next = dur_cnt + 24'd1;
               if (half_period != 17'd0) begin
                  if (half_cnt == half_period - 17'd1) begin
                     half_next  = '0;
                     piezo_next = ~piezo;
                  end else begin
                     half_next = half_cnt + 17'd1;
                  end
               end
            end
         end

         GAP: begin
            piezo_next = 1'b0;
            half_next  = '0;
            if (stop) begin
               state_next = IDLE;
               dur_next   = '0;
            end else if (dur_cnt == GAP_LAST) begin
               state_next = IDLE;
               done_next  = 1'b1;
               dur_next   = '0;
            end else begin
               dur_next = dur_cnt + 24'd1;
            end
         end

         default: begin
            state_next = IDLE;
            piezo_next = 1'b0;
            half_next  = '0;
            dur_next   = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         note_q    <= '0;
         half_cnt  <= '0;
         dur_cnt   <= '0;
         piezo     <= 1'b0;
         note_done <= 1'b0;
      end else begin
         state     <= state_next;
         note_q    <= note_next;
         half_cnt  <= half_next;
         dur_cnt   <= dur_next;
         piezo     <= piezo_next;
         note_done <= done_next;
      end
   end

   // The buzzer only ever sounds in TONE; completion is only flagged in IDLE.
   piezo_only_in_tone: assert property (@(posedge clk) piezo |-> (state == TONE));
   done_only_in_idle:  assert property (@(posedge clk) note_done |-> (state == IDLE));

endmodule
